// File: rtl/band_mixer.sv
// band_mixer: sums the low/mid/high equalizer bands into one mono sample.
// Two register stages with valid/ready flow control. Stage 1 registers the
// widened sum. Stage 2 applies the arithmetic shift, saturates to DATA_W,
// and flags clipped samples.
// Optional feature macro: MIXER_CLIP_CNT_EN adds clip_clr/clip_count, a
// saturating count of clipped samples that were transferred.
`timescale 1ns/1ps
module band_mixer #(
    parameter int DATA_W = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] low_in,
    input  logic signed [DATA_W-1:0] mid_in,
    input  logic signed [DATA_W-1:0] high_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] mix_out,
    output logic                     clip
`ifdef MIXER_CLIP_CNT_EN
    ,
    input  logic                     clip_clr,
    output logic [15:0]              clip_count
`endif
);

    // Two guard bits are enough: three DATA_W values cannot overflow DATA_W+2.
    localparam int SUM_W = DATA_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_POS = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_NEG = {3'b111, {(DATA_W-1){1'b0}}};

    if (SHIFT < 0 || SHIFT > 2) begin : g_bad_shift
        $error("band_mixer: SHIFT must be in 0..2");
    end

    // Sign-extend each band to the sum width.
    logic signed [DATA_W-1:0] band_in  [3];
    logic signed [SUM_W-1:0]  band_ext [3];

    assign band_in[0] = low_in;
    assign band_in[1] = mid_in;
    assign band_in[2] = high_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ext
        assign band_ext[gi] = {{2{band_in[gi][DATA_W-1]}}, band_in[gi]};
    end

    logic                    s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0] s1_sum_q,   s1_sum_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] mix_q,     mix_d;
    logic                    clip_q,     clip_d;

    logic                    s2_adv;
    logic                    s1_adv;
    logic signed [SUM_W-1:0] sh;
    logic signed [DATA_W-1:0] sat_val;
    logic                    sat_clip;

    // Each stage moves when its downstream slot is empty or being drained.
    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Scale and saturate the stage-1 sum into the output range.
    always_comb begin
        sh       = s1_sum_q >>> SHIFT;
        sat_val  = sh[DATA_W-1:0];
        sat_clip = 1'b0;
        if (sh > SAT_POS) begin
            sat_val  = SAT_POS[DATA_W-1:0];
            sat_clip = 1'b1;
        end else if (sh < SAT_NEG) begin
            sat_val  = SAT_NEG[DATA_W-1:0];
            sat_clip = 1'b1;
        end
    end

    // Next-state logic for both pipeline stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        out_valid_d = out_valid_q;
        mix_d       = mix_q;
        clip_d      = clip_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d = band_ext[0] + band_ext[1] + band_ext[2];
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                mix_d  = sat_val;
                clip_d = sat_clip;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            mix_q       <= '0;
            clip_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            mix_q       <= mix_d;
            clip_q      <= clip_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mix_out   = mix_q;
    assign clip      = clip_q;

`ifdef MIXER_CLIP_CNT_EN
    logic [15:0] clip_count_q, clip_count_d;

    // Count clipped samples that actually leave the block. The count sticks
    // at all-ones, and a clear takes priority over an increment.
    always_comb begin
        clip_count_d = clip_count_q;
        if (clip_clr) begin
            clip_count_d = '0;
        end else if (out_valid_q && out_ready && clip_q && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    // Clip counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: table-driven and scoreboard-based bench for band_mixer.
// Two instances share the stimulus, one with SHIFT=0 and one with SHIFT=1.
// Both instances see the same handshakes, so they have identical timing.
// The clip counter tests are compiled only with MIXER_CLIP_CNT_EN.
`timescale 1ns/1ps
module tb_band_mixer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] low_in, mid_in, high_in;
    logic        in_ready0, out_valid0, clip0;
    logic        in_ready1, out_valid1, clip1;
    logic [15:0] mix0, mix1;
`ifdef MIXER_CLIP_CNT_EN
    logic        clip_clr;
    logic [15:0] clip_count0, clip_count1;
`endif

    band_mixer #(.DATA_W(16), .SHIFT(0)) dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .low_in(low_in), .mid_in(mid_in), .high_in(high_in),
        .out_valid(out_valid0), .out_ready(out_ready), .mix_out(mix0), .clip(clip0)
`ifdef MIXER_CLIP_CNT_EN
        , .clip_clr(clip_clr), .clip_count(clip_count0)
`endif
    );

    band_mixer #(.DATA_W(16), .SHIFT(1)) dut_sh1 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .low_in(low_in), .mid_in(mid_in), .high_in(high_in),
        .out_valid(out_valid1), .out_ready(out_ready), .mix_out(mix1), .clip(clip1)
`ifdef MIXER_CLIP_CNT_EN
        , .clip_clr(clip_clr), .clip_count(clip_count1)
`endif
    );

    typedef struct {
        logic [15:0] m0;
        logic        c0;
        logic [15:0] m1;
        logic        c1;
    } exp_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] m;
        logic [15:0] h;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   total = 0;
    int   bad   = 0;
    bit   quiet = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference model: integer sum, arithmetic shift, and saturation to 16 bits.
    function automatic void sat16(input int v, output logic [15:0] m, output logic c);
        if (v > 32767) begin
            m = 16'h7FFF; c = 1'b1;
        end else if (v < -32768) begin
            m = 16'h8000; c = 1'b1;
        end else begin
            m = v[15:0];  c = 1'b0;
        end
    endfunction

    function automatic exp_t mk(input logic [15:0] l, input logic [15:0] m, input logic [15:0] h);
        exp_t r;
        int   s;
        s = int'($signed(l)) + int'($signed(m)) + int'($signed(h));
        sat16(s, r.m0, r.c0);
        sat16(s >>> 1, r.m1, r.c1);
        return r;
    endfunction

    task automatic setv(input int i, input logic [15:0] l, input logic [15:0] m, input logic [15:0] h,
                        input logic [15:0] m0, input logic c0, input logic [15:0] m1, input logic c1);
        tbl[i].l    = l;
        tbl[i].m    = m;
        tbl[i].h    = h;
        tbl[i].e.m0 = m0;
        tbl[i].e.c0 = c0;
        tbl[i].e.m1 = m1;
        tbl[i].e.c1 = c1;
    endtask

    // Monitor: pop and compare on every output transfer; reset discards expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else if (out_valid0 && out_ready) begin
            if (!quiet) begin
                $display("xfer mix0=%h clip0=%b mix1=%h clip1=%b", mix0, clip0, mix1, clip1);
            end
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got mix0=%h expected no output", mix0);
            end else begin
                e = sb.pop_front();
                check("mix0", {16'h0, mix0}, {16'h0, e.m0});
                check("clip0", {31'h0, clip0}, {31'h0, e.c0});
                check("valid1", {31'h0, out_valid1}, 32'd1);
                check("mix1", {16'h0, mix1}, {16'h0, e.m1});
                check("clip1", {31'h0, clip1}, {31'h0, e.c1});
            end
        end
    end

    // Present one triple and hold it until accepted; called at posedge+1.
    task automatic send(input logic [15:0] l, input logic [15:0] m, input logic [15:0] h, input exp_t e);
        int   n;
        logic ok;
        n        = 0;
        low_in   = l;
        mid_in   = m;
        high_in  = h;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready0;
            if (ok) sb.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t     e;
        logic [15:0] hold;
        bit       dropped;
        logic [15:0] r0, r1, r2;

        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        low_in   = '0;
        mid_in   = '0;
        high_in  = '0;
`ifdef MIXER_CLIP_CNT_EN
        clip_clr = 1'b0;
`endif
        //   idx  low       mid       high      mix0     c0  mix1     c1
        setv(0,  16'h03E8, 16'h07D0, 16'hFE0C, 16'h09C4, 0, 16'h04E2, 0);
        setv(1,  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 1);
        setv(2,  16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 16'h8000, 1);
        setv(3,  16'h4E20, 16'h4E20, 16'h4E20, 16'h7FFF, 1, 16'h7530, 0);
        setv(4,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        setv(5,  16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 0, 16'h3FFF, 0);
        setv(6,  16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 1, 16'h4000, 0);
        setv(7,  16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1, 16'hBFFF, 0);
        setv(8,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD, 0, 16'hFFFE, 0);
        setv(9,  16'h4000, 16'h4000, 16'h0000, 16'h7FFF, 1, 16'h4000, 0);
        setv(10, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 0, 16'hC000, 0);
        setv(11, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 0, 16'h0003, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid0}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready0}, 32'd1);
        check("rst_mix", {16'h0, mix0}, 32'd0);
        check("rst_clip", {31'h0, clip0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: one accept, out_valid is low after one edge and high after two.
        low_in   = 16'h03E8;
        mid_in   = 16'h07D0;
        high_in  = 16'hFE0C;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", {31'h0, in_ready0}, 32'd1);
        sb.push_back(mk(low_in, mid_in, high_in));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_1clk_valid", {31'h0, out_valid0}, 32'd0);
        @(negedge clk);
        check("lat_2clk_valid", {31'h0, out_valid0}, 32'd1);
        @(posedge clk);
        #1;

        // Vector table, back to back at full rate.
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].l, tbl[i].m, tbl[i].h, tbl[i].e);
        end
        in_valid = 1'b0;
        drain();

        // Random samples checked against the model.
        for (int i = 0; i < 20; i++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            send(r0, r1, r2, mk(r0, r1, r2));
        end
        in_valid = 1'b0;
        drain();

        // Stall mid-stream: 8 samples, out_ready low for 5 cycles.
        dropped = 1'b0;
        hold    = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    r0 = 16'(1000 * i);
                    r1 = 16'(20000 + i);
                    r2 = 16'(i);
                    send(r0, r1, r2, mk(r0, r1, r2));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) hold = mix0;
                    check("stall_valid", {31'h0, out_valid0}, 32'd1);
                    check("stall_mix_stable", {16'h0, mix0}, {16'h0, hold});
                    if (!in_ready0) dropped = 1'b1;
                    #1;
                    check("stall_depth_le2", {31'h0, (sb.size() <= 2)}, 32'd1);
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
                check("stall_in_ready_dropped", {31'h0, dropped}, 32'd1);
            end
        join
        drain();

        // Reset with two samples in flight: they must never appear.
        e = mk(16'h7FFF, 16'h7FFF, 16'h7FFF);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_out_valid", {31'h0, out_valid0}, 32'd0);
        check("midrst_in_ready", {31'h0, in_ready0}, 32'd1);
        check("midrst_mix", {16'h0, mix0}, 32'd0);
        check("midrst_clip", {31'h0, clip0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_no_ghost", {31'h0, out_valid0}, 32'd0);
        @(posedge clk);
        #1;

`ifdef MIXER_CLIP_CNT_EN
        // Clip counter: three counted clips.
        e = mk(16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 3; i++) send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("cnt_three", {16'h0, clip_count0}, 32'd3);
        @(posedge clk);
        #1;

        // Clear in the same cycle as a counted clip: the clear wins.
        out_ready = 1'b0;
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("cnt_pending_valid", {31'h0, out_valid0}, 32'd1);
        out_ready = 1'b1;
        clip_clr  = 1'b1;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
        @(negedge clk);
        check("cnt_clear_wins", {16'h0, clip_count0}, 32'd0);
        @(posedge clk);
        #1;

        // Saturation at 0xFFFF.
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("cnt_full", {16'h0, clip_count0}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, e);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("cnt_no_wrap", {16'h0, clip_count0}, 32'h0000FFFF);
        quiet = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
